// File: rtl/loader_pkg.sv
// Shared definitions for program_loader: FSM state encoding, host op codes
// carried in bits [15:14] of the command word, and run-result status codes.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CNT,
    S_DATA,
    S_RUN,
    S_REPORT
  } state_e;

  typedef enum logic [1:0] {
    OP_IMEM = 2'b00,
    OP_DMEM = 2'b01,
    OP_RUN  = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_NONE    = 2'b00,
    ST_HALT    = 2'b01,
    ST_TIMEOUT = 2'b10
  } status_e;

  // States in which the loader consumes host words.
  function automatic logic accepts_host(state_e s);
    return (s == S_IDLE) || (s == S_ADDR) || (s == S_CNT) || (s == S_DATA);
  endfunction

endpackage

// File: rtl/program_loader.sv
// Host-driven program loader: streams command/address/count/data words into
// CPU instruction or data memory, then releases the CPU from reset and
// reports the last nonzero Out_R value once the CPU halts.
// Optional feature: define LOADER_TIMEOUT_EN to abort a run after
// TIMEOUT_CYCLES cycles without a halt (status 10).
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk_i,
  input  logic        rst_n,
  // host command/data stream
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  // run result
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic [1:0]  m_status,
  // CPU control
  output logic        cpu_rst_n,
  output logic        ex_iwe,
  output logic [15:0] ex_iaddr,
  output logic [15:0] ex_idata,
  output logic        ex_dwe,
  output logic [15:0] ex_daddr,
  output logic [15:0] ex_ddata,
  input  logic [15:0] cpu_out_r,
  input  logic        cpu_flag_done
);

  state_e      state_q, state_d;
  logic        is_dmem_q, is_dmem_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] capture_q, capture_d;
  status_e     status_q, status_d;
  logic        cpu_rst_n_q, cpu_rst_n_d;
  logic        iwe_q, iwe_d;
  logic [15:0] iaddr_q, iaddr_d;
  logic [15:0] idata_q, idata_d;
  logic        dwe_q, dwe_d;
  logic [15:0] daddr_q, daddr_d;
  logic [15:0] ddata_q, ddata_d;

  logic        accept;
  logic        timeout_hit;

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] run_cnt_q, run_cnt_d;

  // Count cycles spent in RUN (the only state with cpu_rst_n high); idle at zero elsewhere
  always_comb begin
    run_cnt_d = '0;
    if (state_q == S_RUN) begin
      run_cnt_d = run_cnt_q + 32'd1;
    end
  end

  // Run cycle counter register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end

  // The current RUN cycle is the TIMEOUT_CYCLES-th one
  assign timeout_hit = (state_q == S_RUN) && ((run_cnt_q + 32'd1) >= TIMEOUT_CYCLES);
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  // Reset holds s_ready low even though the state register already reads IDLE
  assign s_ready = rst_n && accepts_host(state_q);
  assign accept  = s_valid && s_ready;

  // Next-state, datapath and write-strobe decode; every target defaulted first
  always_comb begin
    state_d   = state_q;
    is_dmem_d = is_dmem_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    capture_d = capture_q;
    status_d  = status_q;
    iwe_d     = 1'b0;
    iaddr_d   = iaddr_q;
    idata_d   = idata_q;
    dwe_d     = 1'b0;
    daddr_d   = daddr_q;
    ddata_d   = ddata_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op_e'(s_data[15:14]))
            OP_IMEM: begin
              is_dmem_d = 1'b0;
              state_d   = S_ADDR;
            end
            OP_DMEM: begin
              is_dmem_d = 1'b1;
              state_d   = S_ADDR;
            end
            OP_RUN: begin
              capture_d = '0;
              state_d   = S_RUN;
            end
            default: ;
          endcase
        end
      end

      S_ADDR: begin
        if (accept) begin
          addr_d  = s_data;
          state_d = S_CNT;
        end
      end

      S_CNT: begin
        if (accept) begin
          cnt_d   = s_data;
          state_d = (s_data == '0) ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (accept) begin
          if (is_dmem_q) begin
            dwe_d   = 1'b1;
            daddr_d = addr_q;
            ddata_d = s_data;
          end else begin
            iwe_d   = 1'b1;
            iaddr_d = addr_q;
            idata_d = s_data;
          end
          addr_d = addr_q + 16'd1;
          cnt_d  = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_d = S_IDLE;
          end
        end
      end

      S_RUN: begin
        if (cpu_out_r != '0) begin
          capture_d = cpu_out_r;
        end
        // A halt in the same cycle as the timeout takes precedence
        if (cpu_flag_done) begin
          status_d = ST_HALT;
          state_d  = S_REPORT;
        end else if (timeout_hit) begin
          status_d = ST_TIMEOUT;
          state_d  = S_REPORT;
        end
      end

      S_REPORT: begin
        if (m_ready) begin
          status_d = ST_NONE;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered so the CPU reset is glitch-free and rises the cycle after the run command
    cpu_rst_n_d = (state_d == S_RUN);
  end

  // State and datapath registers; asynchronous reset abandons any load or run
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      is_dmem_q   <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      capture_q   <= '0;
      status_q    <= ST_NONE;
      cpu_rst_n_q <= 1'b0;
      iwe_q       <= 1'b0;
      iaddr_q     <= '0;
      idata_q     <= '0;
      dwe_q       <= 1'b0;
      daddr_q     <= '0;
      ddata_q     <= '0;
    end else begin
      state_q     <= state_d;
      is_dmem_q   <= is_dmem_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      capture_q   <= capture_d;
      status_q    <= status_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      iwe_q       <= iwe_d;
      iaddr_q     <= iaddr_d;
      idata_q     <= idata_d;
      dwe_q       <= dwe_d;
      daddr_q     <= daddr_d;
      ddata_q     <= ddata_d;
    end
  end

  assign m_valid   = (state_q == S_REPORT);
  assign m_data    = capture_q;
  assign m_status  = status_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign ex_iwe    = iwe_q;
  assign ex_iaddr  = iaddr_q;
  assign ex_idata  = idata_q;
  assign ex_dwe    = dwe_q;
  assign ex_daddr  = daddr_q;
  assign ex_ddata  = ddata_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader. Expected memory writes and run
// results come from a plain behavioural model of the host protocol.
// Define LOADER_TIMEOUT_EN for both files to exercise the timeout path.
module tb_program_loader;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        m_ready = 1'b0;
  logic [15:0] cpu_out_r = '0;
  logic        cpu_flag_done = 1'b0;

  logic        s_ready, m_valid, cpu_rst_n, ex_iwe, ex_dwe;
  logic [15:0] m_data, ex_iaddr, ex_idata, ex_daddr, ex_ddata;
  logic [1:0]  m_status;

  typedef struct packed {
    logic        is_i;
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         obs_q[$];
  logic [15:0] payload[$];
  bit          both_high = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  program_loader #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_status(m_status),
    .cpu_rst_n(cpu_rst_n),
    .ex_iwe(ex_iwe), .ex_iaddr(ex_iaddr), .ex_idata(ex_idata),
    .ex_dwe(ex_dwe), .ex_daddr(ex_daddr), .ex_ddata(ex_ddata),
    .cpu_out_r(cpu_out_r), .cpu_flag_done(cpu_flag_done)
  );

  always #5 clk_i = ~clk_i;

  // Record every write strobe seen by the memories
  always @(negedge clk_i) begin
    if (rst_n) begin
      if (ex_iwe && ex_dwe) both_high = 1'b1;
      if (ex_iwe) obs_q.push_back({1'b1, ex_iaddr, ex_idata});
      if (ex_dwe) obs_q.push_back({1'b0, ex_daddr, ex_ddata});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1);
  end

  // Present one word from a negedge; returns at the negedge after it is taken
  task automatic send_word(input logic [15:0] w, input int gap);
    int waited;
    repeat (gap) @(negedge clk_i);
    s_valid = 1'b1;
    s_data  = w;
    waited  = 0;
    while (!s_ready && waited < 50) begin
      @(negedge clk_i);
      waited++;
    end
    if (!s_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake: got s_ready=0 for 50 cycles exp 1 (word %h)", w);
    end else begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
    s_valid = 1'b0;
    s_data  = 16'($urandom);
  endtask

  // Send a full load of the current payload and extend the expected write list
  task automatic do_load(input bit dmem, input logic [15:0] addr, input int maxgap,
                         input logic [13:0] junk);
    logic [15:0] a;
    wr_t         w;
    send_word({(dmem ? 2'b01 : 2'b00), junk}, $urandom_range(maxgap, 0));
    send_word(addr, $urandom_range(maxgap, 0));
    send_word(16'(payload.size()), $urandom_range(maxgap, 0));
    a = addr;
    foreach (payload[k]) begin
      w.is_i = !dmem;
      w.a    = a;
      w.d    = payload[k];
      exp_q.push_back(w);
      a = a + 16'd1;
      send_word(payload[k], $urandom_range(maxgap, 0));
    end
  endtask

  task automatic ack_report();
    m_ready = 1'b1;
    @(negedge clk_i);
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    n_checks++;
    if ({s_ready, m_valid, m_data, m_status, cpu_rst_n} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b mv=%b md=%h ms=%b crst=%b exp all 0",
               s_ready, m_valid, m_data, m_status, cpu_rst_n);
    end
    n_checks++;
    if ({ex_iwe, ex_iaddr, ex_idata, ex_dwe, ex_daddr, ex_ddata} !== '0) begin
      n_fail++;
      $display("FAIL reset_ex: got %b %h %h %b %h %h exp all 0",
               ex_iwe, ex_iaddr, ex_idata, ex_dwe, ex_daddr, ex_ddata);
    end
    #2 rst_n = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (s_ready !== 1'b1 || cpu_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got s_ready=%b cpu_rst_n=%b exp 1 0", s_ready, cpu_rst_n);
    end
  endtask

  task automatic test_load_imem();
    payload = '{16'h1111, 16'h2222, 16'h3333};
    do_load(1'b0, 16'h0010, 0, 14'h0000);
    repeat (2) @(negedge clk_i);
    #1;
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL imem_count: got %0d writes exp %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL imem_write[%0d]: got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
    n_checks++;
    if (ex_iaddr !== 16'h0012 || ex_idata !== 16'h3333 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL imem_hold: got addr=%h data=%h rdy=%b exp 0012 3333 1",
               ex_iaddr, ex_idata, s_ready);
    end
  endtask

  task automatic test_load_dmem_wrap();
    payload = '{16'($urandom), 16'($urandom)};
    do_load(1'b1, 16'hFFFF, 1, 14'($urandom));
    repeat (2) @(negedge clk_i);
    #1;
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL dmem_wrap_count: got %0d writes exp %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL dmem_wrap_write[%0d]: got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_zero_count_and_nop();
    send_word({2'b00, 14'($urandom)}, 0);
    send_word(16'($urandom), 0);
    send_word(16'h0000, 0);
    send_word({2'b11, 14'($urandom)}, 1);
    repeat (3) @(negedge clk_i);
    n_checks++;
    if (obs_q.size() !== 0 || s_ready !== 1'b1 || cpu_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_nop: got writes=%0d rdy=%b crst=%b exp 0 1 0",
               obs_q.size(), s_ready, cpu_rst_n);
    end
    payload = '{16'($urandom)};
    do_load(1'b1, 16'($urandom), 0, 14'($urandom));
    repeat (2) @(negedge clk_i);
    #1;
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL after_nop_count: got %0d writes exp %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL after_nop_write[%0d]: got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random_loads();
    for (int it = 0; it < 8; it++) begin
      int          n    = $urandom_range(6, 1);
      bit          dmem = 1'($urandom);
      logic [15:0] addr = (it % 3 == 0) ? 16'hFFFE : 16'($urandom);
      payload.delete();
      for (int k = 0; k < n; k++) payload.push_back(16'($urandom));
      do_load(dmem, addr, 2, 14'($urandom));
    end
    repeat (2) @(negedge clk_i);
    #1;
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_load_count: got %0d writes exp %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_load_write[%0d]: got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
    n_checks++;
    if (both_high !== 1'b0) begin
      n_fail++;
      $display("FAIL strobe_exclusive: got both strobes high exp never");
    end
  endtask

  task automatic test_run_directed();
    logic [15:0] md;
    logic [1:0]  ms;
    send_word(16'h8000, 0);
    n_checks++;
    if (cpu_rst_n !== 1'b1 || s_ready !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL run_entry: got crst=%b rdy=%b mv=%b exp 1 0 0", cpu_rst_n, s_ready, m_valid);
    end
    cpu_out_r = 16'h0005;
    @(negedge clk_i);
    cpu_out_r = 16'h0000;
    @(negedge clk_i);
    cpu_out_r = 16'h0007;
    @(negedge clk_i);
    cpu_out_r = 16'h0000;
    cpu_flag_done = 1'b1;
    @(negedge clk_i);
    cpu_flag_done = 1'b0;
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 16'h0007 || m_status !== 2'b01 || cpu_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL run_report: got mv=%b md=%h ms=%b crst=%b exp 1 0007 01 0",
               m_valid, m_data, m_status, cpu_rst_n);
    end
    md = 16'h0007;
    ms = 2'b01;
    for (int c = 0; c < 3; c++) begin
      cpu_out_r = 16'($urandom);
      @(negedge clk_i);
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== md || m_status !== ms) begin
        n_fail++;
        $display("FAIL report_stable[%0d]: got mv=%b md=%h ms=%b exp 1 %h %b",
                 c, m_valid, m_data, m_status, md, ms);
      end
    end
    cpu_out_r = '0;
    ack_report();
    n_checks++;
    if (m_valid !== 1'b0 || m_status !== 2'b00 || cpu_rst_n !== 1'b0 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL report_ack: got mv=%b ms=%b crst=%b rdy=%b exp 0 00 0 1",
               m_valid, m_status, cpu_rst_n, s_ready);
    end
  endtask

  task automatic test_random_runs();
    for (int it = 0; it < 6; it++) begin
      int          len  = $urandom_range(6, 0);
      logic [15:0] expv = '0;
      logic [15:0] v;
      send_word({2'b10, 14'($urandom)}, $urandom_range(2, 0));
      for (int c = 0; c <= len; c++) begin
        v = (it == 0 || $urandom_range(2, 0) == 0) ? 16'h0000 : 16'($urandom);
        cpu_out_r     = v;
        cpu_flag_done = (c == len);
        if (v != 16'h0000) expv = v;
        @(negedge clk_i);
      end
      cpu_flag_done = 1'b0;
      cpu_out_r     = '0;
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== expv || m_status !== 2'b01 || cpu_rst_n !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_run[%0d]: got mv=%b md=%h ms=%b crst=%b exp 1 %h 01 0",
                 it, m_valid, m_data, m_status, cpu_rst_n, expv);
      end
      repeat ($urandom_range(2, 0)) @(negedge clk_i);
      ack_report();
      n_checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_run_ack[%0d]: got mv=%b rdy=%b exp 0 1", it, m_valid, s_ready);
      end
    end
  endtask

  task automatic test_timeout();
`ifdef LOADER_TIMEOUT_EN
    send_word(16'h8000, 0);
    for (int c = 0; c < 8; c++) begin
      n_checks++;
      if (m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_early[%0d]: got m_valid=%b exp 0", c, m_valid);
      end
      @(negedge clk_i);
    end
    n_checks++;
    if (m_valid !== 1'b1 || m_status !== 2'b10 || m_data !== 16'h0000 || cpu_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_report: got mv=%b ms=%b md=%h crst=%b exp 1 10 0000 0",
               m_valid, m_status, m_data, cpu_rst_n);
    end
    ack_report();
    send_word(16'h8000, 0);
    repeat (7) @(negedge clk_i);
    cpu_flag_done = 1'b1;
    @(negedge clk_i);
    cpu_flag_done = 1'b0;
    n_checks++;
    if (m_valid !== 1'b1 || m_status !== 2'b01) begin
      n_fail++;
      $display("FAIL done_vs_timeout: got mv=%b ms=%b exp 1 01", m_valid, m_status);
    end
    ack_report();
`else
    send_word(16'h8000, 0);
    repeat (40) @(negedge clk_i);
    n_checks++;
    if (m_valid !== 1'b0 || cpu_rst_n !== 1'b1) begin
      n_fail++;
      $display("FAIL no_timeout: got mv=%b crst=%b exp 0 1", m_valid, cpu_rst_n);
    end
    cpu_flag_done = 1'b1;
    @(negedge clk_i);
    cpu_flag_done = 1'b0;
    n_checks++;
    if (m_valid !== 1'b1 || m_status !== 2'b01) begin
      n_fail++;
      $display("FAIL long_run_halt: got mv=%b ms=%b exp 1 01", m_valid, m_status);
    end
    ack_report();
`endif
  endtask

  task automatic test_back_to_back();
    payload = '{16'($urandom), 16'($urandom), 16'($urandom)};
    do_load(1'b0, 16'($urandom), 0, 14'($urandom));
    send_word({2'b10, 14'($urandom)}, 0);
    cpu_out_r     = 16'h00AB;
    cpu_flag_done = 1'b1;
    @(negedge clk_i);
    cpu_flag_done = 1'b0;
    cpu_out_r     = '0;
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 16'h00AB || m_status !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_report: got mv=%b md=%h ms=%b exp 1 00ab 01", m_valid, m_data, m_status);
    end
    ack_report();
    #1;
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d writes exp %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_write[%0d]: got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    wr_t         w;
    logic [15:0] addr = 16'($urandom);
    logic [15:0] d0 = 16'($urandom);
    logic [15:0] d1 = 16'($urandom);
    send_word({2'b00, 14'($urandom)}, 0);
    send_word(addr, 0);
    send_word(16'd4, 0);
    send_word(d0, 0);
    send_word(d1, 1);
    w = {1'b1, addr, d0};
    exp_q.push_back(w);
    w = {1'b1, addr + 16'd1, d1};
    exp_q.push_back(w);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({s_ready, m_valid, cpu_rst_n, ex_iwe, ex_iaddr, ex_idata, ex_dwe} !== '0) begin
      n_fail++;
      $display("FAIL mid_data_reset: got rdy=%b mv=%b crst=%b iwe=%b ia=%h id=%h dwe=%b exp all 0",
               s_ready, m_valid, cpu_rst_n, ex_iwe, ex_iaddr, ex_idata, ex_dwe);
    end
    @(negedge clk_i);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk_i);
    #1;
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL mid_data_count: got %0d writes exp %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL mid_data_write[%0d]: got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
    n_checks++;
    if (s_ready !== 1'b1 || cpu_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_data_idle: got rdy=%b crst=%b exp 1 0", s_ready, cpu_rst_n);
    end
    @(negedge clk_i);
    send_word({2'b10, 14'($urandom)}, 0);
    cpu_out_r = 16'h0009;
    repeat (3) @(negedge clk_i);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (cpu_rst_n !== 1'b0 || m_valid !== 1'b0 || m_data !== 16'h0000 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_run_reset: got crst=%b mv=%b md=%h rdy=%b exp 0 0 0000 0",
               cpu_rst_n, m_valid, m_data, s_ready);
    end
    cpu_out_r = '0;
    @(negedge clk_i);
    #2 rst_n = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (s_ready !== 1'b1 || cpu_rst_n !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_run_idle: got rdy=%b crst=%b mv=%b exp 1 0 0", s_ready, cpu_rst_n, m_valid);
    end
  endtask

  initial begin
    test_reset();
    test_load_imem();
    test_load_dmem_wrap();
    test_zero_count_and_nop();
    test_random_loads();
    test_run_directed();
    test_random_runs();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
